// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the packed-SIMD dot-product-accumulate unit.
package mac_pkg;

    localparam int unsigned XLEN_DEF = 32;

    // Width of the reduced lane-product sum: two (W+1)-bit signed factors plus tree growth.
    function automatic int unsigned sum_width(input int unsigned xlen, input int unsigned lanes);
        return 2 * (xlen / lanes) + 2 + $clog2(lanes);
    endfunction

    typedef struct packed {
        logic [XLEN_DEF-1:0] a;
        logic [XLEN_DEF-1:0] b;
        logic                a_signed;
        logic                b_signed;
        logic                acc_en;
    } op_t;

endpackage

// File: rtl/mac_lane_mul.sv
// One SIMD lane: extend each W-bit operand by one bit (sign or zero) and form the signed product.
module mac_lane_mul #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]         a_i,
    input  logic [W-1:0]         b_i,
    input  logic                 a_signed_i,
    input  logic                 b_signed_i,
    output logic signed [2*W+1:0] prod_o
);

    logic signed [W:0] a_ext;
    logic signed [W:0] b_ext;

    always_comb begin
        a_ext  = {a_signed_i & a_i[W-1], a_i};
        b_ext  = {b_signed_i & b_i[W-1], b_i};
        prod_o = (2*W+2)'(a_ext) * (2*W+2)'(b_ext);
    end

endmodule

// File: rtl/simd_dot_acc.sv
// Pipelined packed-SIMD dot-product-accumulate: operand register, lane multiply, reduce, accumulate.
// Define MAC_SATURATE_EN for a saturating accumulator with sat_o; otherwise it wraps.
module simd_dot_acc
    import mac_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned LANES = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            a_signed_i,
    input  logic            b_signed_i,
    input  logic            acc_en_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            sat_o
);

    localparam int unsigned W     = XLEN / LANES;
    localparam int unsigned PW    = 2 * W + 2;
    localparam int unsigned SUM_W = sum_width(XLEN, LANES);
    localparam int unsigned EXT_W = ((SUM_W > XLEN) ? SUM_W : XLEN) + 1;

    logic advance;

    logic s1_v_q, s1_v_d;
    op_t  op_q, op_d;

    logic                 s2_v_q, s2_v_d;
    logic                 s2_en_q, s2_en_d;
    logic signed [PW-1:0] prod   [LANES];
    logic signed [PW-1:0] prod_q [LANES];
    logic signed [PW-1:0] prod_d [LANES];

    logic                    sum_v_q, sum_v_d;
    logic                    sum_en_q, sum_en_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic signed [SUM_W-1:0] node [2*LANES-1];

    logic            out_v_q, out_v_d;
    logic [XLEN-1:0] acc_q, acc_d, acc_new;
    logic            sat_q, sat_d, sat_new;

    assign advance     = !out_v_q || out_ready_i;
    assign in_ready_o  = advance || flush_i;
    assign out_valid_o = out_v_q;
    assign result_o    = acc_q;
    assign sat_o       = sat_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mac_lane_mul #(
            .W(W)
        ) u_mul (
            .a_i        (op_q.a[k*W +: W]),
            .b_i        (op_q.b[k*W +: W]),
            .a_signed_i (op_q.a_signed),
            .b_signed_i (op_q.b_signed),
            .prod_o     (prod[k])
        );
    end

    // Heap-indexed adder tree: leaves at LANES-1.., node[i] sums children 2i+1 and 2i+2.
    always_comb begin
        for (int k = 0; k < int'(LANES); k++) begin
            node[int'(LANES) - 1 + k] = SUM_W'(prod_q[k]);
        end
        for (int i = int'(LANES) - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
    end

`ifdef MAC_SATURATE_EN
    logic signed [EXT_W-1:0]  tot;
    logic        [EXT_W-XLEN:0] top_bits;

    always_comb begin
        tot = EXT_W'(sum_q);
        if (sum_en_q) begin
            tot = tot + EXT_W'($signed(acc_q));
        end
        top_bits = tot[EXT_W-1:XLEN-1];
        sat_new  = !((&top_bits) || !(|top_bits));
        acc_new  = tot[XLEN-1:0];
        if (sat_new) begin
            acc_new = tot[EXT_W-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
        end
    end
`else
    always_comb begin
        acc_new = XLEN'(sum_q);
        if (sum_en_q) begin
            acc_new = acc_q + XLEN'(sum_q);
        end
    end
    assign sat_new = 1'b0;
`endif

    always_comb begin
        s1_v_d   = s1_v_q;
        op_d     = op_q;
        s2_v_d   = s2_v_q;
        s2_en_d  = s2_en_q;
        prod_d   = prod_q;
        sum_v_d  = sum_v_q;
        sum_d    = sum_q;
        sum_en_d = sum_en_q;
        out_v_d  = out_v_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        if (advance) begin
            s1_v_d            = in_valid_i;
            op_d              = '0;
            op_d.a[XLEN-1:0]  = operand_a_i;
            op_d.b[XLEN-1:0]  = operand_b_i;
            op_d.a_signed     = a_signed_i;
            op_d.b_signed     = b_signed_i;
            op_d.acc_en       = acc_en_i;
            s2_v_d            = s1_v_q;
            s2_en_d           = op_q.acc_en;
            prod_d            = prod;
            sum_v_d           = s2_v_q;
            sum_d             = node[0];
            sum_en_d          = s2_en_q;
            out_v_d           = sum_v_q;
            // Bubbles reaching the last stage leave the accumulator untouched.
            if (sum_v_q) begin
                acc_d = acc_new;
                sat_d = sat_new;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q   <= 1'b0;
            op_q     <= '0;
            s2_v_q   <= 1'b0;
            s2_en_q  <= 1'b0;
            prod_q   <= '{default: '0};
            sum_v_q  <= 1'b0;
            sum_q    <= '0;
            sum_en_q <= 1'b0;
            out_v_q  <= 1'b0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
        end else if (flush_i) begin
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            sum_v_q <= 1'b0;
            out_v_q <= 1'b0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            op_q     <= op_d;
            s2_v_q   <= s2_v_d;
            s2_en_q  <= s2_en_d;
            prod_q   <= prod_d;
            sum_v_q  <= sum_v_d;
            sum_q    <= sum_d;
            sum_en_q <= sum_en_d;
            out_v_q  <= out_v_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_simd_dot_acc.sv
// Scoreboard bench for simd_dot_acc: a LANES=4 and a LANES=2 instance share one stimulus stream.
module tb_simd_dot_acc;

    logic        clk = 1'b0;
    logic        rst, in_valid, a_s, b_s, acc_en, flush, out_ready;
    logic [31:0] op_a, op_b;
    logic        in_ready4, out_valid4, sat4, in_ready2, out_valid2, sat2;
    logic [31:0] res4, res2;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] q4[$];
    logic [32:0] q2[$];
    longint      acc4 = 0;
    longint      acc2 = 0;
    bit          stall4 = 0, stall2 = 0;
    logic [31:0] hold4, hold2;
    logic [32:0] e4, e2;
    logic [31:0] bp_exp [5] = '{32'h1C, 32'h38, 32'h54, 32'h70, 32'h8C};

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    always #5 clk = ~clk;

    simd_dot_acc #(.XLEN(32), .LANES(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
        .operand_a_i(op_a), .operand_b_i(op_b), .a_signed_i(a_s), .b_signed_i(b_s),
        .acc_en_i(acc_en), .flush_i(flush), .out_valid_o(out_valid4), .out_ready_i(out_ready),
        .result_o(res4), .sat_o(sat4)
    );

    simd_dot_acc #(.XLEN(32), .LANES(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .operand_a_i(op_a), .operand_b_i(op_b), .a_signed_i(a_s), .b_signed_i(b_s),
        .acc_en_i(acc_en), .flush_i(flush), .out_valid_o(out_valid2), .out_ready_i(out_ready),
        .result_o(res2), .sat_o(sat2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Exact dot product of the lane pairs as plain integers.
    function automatic longint dot(input logic [31:0] a, input logic [31:0] b, input bit as,
                                   input bit bs, input int lanes);
        int     w;
        longint m, av, bv, s;
        w = 32 / lanes;
        m = (longint'(1) << w) - 1;
        s = 0;
        for (int k = 0; k < lanes; k++) begin
            av = (longint'(a) >> (k * w)) & m;
            bv = (longint'(b) >> (k * w)) & m;
            if (as && av[w-1]) av = av - (longint'(1) << w);
            if (bs && bv[w-1]) bv = bv - (longint'(1) << w);
            s += av * bv;
        end
        return s;
    endfunction

    task automatic model_apply(input longint sum, input bit en, inout longint acc,
                               output logic [32:0] e);
        longint t;
        bit     sat;
        sat = 0;
        t   = en ? acc + sum : sum;
`ifdef MAC_SATURATE_EN
        if (t > SMAX) begin
            t = SMAX; sat = 1;
        end else if (t < SMIN) begin
            t = SMIN; sat = 1;
        end
`else
        t = t & 64'hFFFF_FFFF;
`endif
        acc = t;
        e   = {sat, t[31:0]};
    endtask

    // One clock of stimulus; pushes the expected result when the operation is accepted.
    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b, input bit as,
                         input bit bs, input bit en, input bit rdy, input bit ov4,
                         input logic [32:0] x4, input bit ov2, input logic [32:0] x2,
                         output bit got);
        logic [32:0] m4, m2;
        @(posedge clk);
        #1;
        in_valid = v; op_a = a; op_b = b; a_s = as; b_s = bs; acc_en = en; out_ready = rdy;
        @(negedge clk);
        got = v && in_ready4;
        if (got) begin
            model_apply(dot(a, b, as, bs, 4), en, acc4, m4);
            model_apply(dot(a, b, as, bs, 2), en, acc2, m2);
            q4.push_back(ov4 ? x4 : m4);
            q2.push_back(ov2 ? x2 : m2);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit as, input bit bs,
                         input bit en, input bit ov4, input logic [32:0] x4, input bit ov2,
                         input logic [32:0] x2);
        bit got;
        int n;
        got = 0;
        n   = 0;
        while (!got && n < 50) begin
            drive(1'b1, a, b, as, bs, en, 1'b1, ov4, x4, ov2, x2, got);
            n++;
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit got;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 0, 0, 0, 1'b1, 0, '0, 0, '0, got);
    endtask

    task automatic do_kill(input bit is_rst);
        @(posedge clk);
        #1;
        if (is_rst) rst = 1'b1;
        else        flush = 1'b1;
        in_valid = 1'b1; op_a = $urandom; op_b = $urandom; out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (!is_rst) chk("flush_in_ready", in_ready4, 1);
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        q4.delete(); q2.delete();
        acc4 = 0; acc2 = 0;
        @(negedge clk);
        chk("kill_valid4", out_valid4, 0);
        chk("kill_acc4", res4, 0);
        chk("kill_valid2", out_valid2, 0);
        chk("kill_acc2", res2, 0);
        chk("kill_sat2", sat2, 0);
    endtask

    always @(negedge clk) begin
        if (rst || flush) begin
            stall4 = 0;
        end else begin
            if (stall4) begin
                chk("hold_valid4", out_valid4, 1);
                chk("hold_result4", res4, hold4);
            end
            if (out_valid4 && out_ready) begin
                if (q4.size() == 0) chk("spurious4", 64'd1, 64'd0);
                else begin
                    e4 = q4.pop_front();
                    chk("result4", {sat4, res4}, e4);
                end
                stall4 = 0;
            end else if (out_valid4) begin
                chk("stall_in_ready4", in_ready4, 0);
                stall4 = 1;
                hold4  = res4;
            end else begin
                stall4 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst || flush) begin
            stall2 = 0;
        end else begin
            if (stall2) chk("hold_result2", res2, hold2);
            if (out_valid2 && out_ready) begin
                if (q2.size() == 0) chk("spurious2", 64'd1, 64'd0);
                else begin
                    e2 = q2.pop_front();
                    chk("result2", {sat2, res2}, e2);
                end
                stall2 = 0;
            end else if (out_valid2) begin
                stall2 = 1;
                hold2  = res2;
            end else begin
                stall2 = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        int idx;
        logic [32:0] sat_exp;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0;
        a_s = 1'b0; b_s = 1'b0; acc_en = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid4", out_valid4, 0);
        chk("rst_result4", res4, 0);
        chk("rst_sat4", sat4, 0);
        chk("rst_in_ready4", in_ready4, 1);
        chk("rst_valid2", out_valid2, 0);

        // Mixed signedness and three-cycle latency.
        issue(32'hFF020304, 32'h01020304, 1, 0, 0, 1, {1'b0, 32'h1C}, 0, '0);
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            chk("latency_valid4", out_valid4, (i == 4));
        end
        issue(32'hFF020304, 32'h01020304, 0, 0, 0, 1, {1'b0, 32'h11C}, 0, '0);
        idle(5);

        // Accumulation back-to-back, then with idle gaps.
        for (int i = 0; i < 3; i++)
            issue(32'hFF020304, 32'h01020304, 1, 0, (i != 0), 1, {1'b0, bp_exp[i]}, 0, '0);
        idle(5);
        for (int i = 0; i < 3; i++) begin
            issue(32'hFF020304, 32'h01020304, 1, 0, (i != 0), 1, {1'b0, bp_exp[i]}, 0, '0);
            idle(1);
        end
        idle(5);

        // Backpressure: consumer stalls four cycles once the first result appears.
        idx = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            drive(1'b1, 32'hFF020304, 32'h01020304, 1, 0, (idx != 0), !(c >= 4 && c < 8),
                  1, {1'b0, bp_exp[idx]}, 0, '0, got);
            if (got) idx++;
        end
        chk("bp_all_accepted", idx, 5);
        idle(8);

        // Saturation boundary on the two-lane instance.
`ifdef MAC_SATURATE_EN
        sat_exp = {1'b1, 32'h7FFF_FFFF};
`else
        sat_exp = {1'b0, 32'h8000_0000};
`endif
        issue(32'h80008000, 32'h80008000, 1, 1, 0, 0, '0, 1, sat_exp);
        idle(5);

        // Flush, then reset, with three operations in flight.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++)
                issue($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 0, '0, 0, '0);
            do_kill(k == 1);
            issue(32'h1, 32'h5, 0, 0, 1, 1, {1'b0, 32'h5}, 1, {1'b0, 32'h5});
            idle(5);
        end

        // Random traffic with random backpressure and occasional flushes.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_kill(1'b0);
            end else begin
                drive($urandom_range(0, 9) < 7, $urandom, $urandom, 1'($urandom), 1'($urandom),
                      1'($urandom_range(0, 3) != 0), $urandom_range(0, 9) < 7,
                      0, '0, 0, '0, got);
            end
        end
        idle(10);
        chk("drain_q4", q4.size(), 0);
        chk("drain_q2", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_dot_acc.md
# simd_dot_acc

Parametrised, pipelined packed-SIMD dot-product-accumulate unit for the CVA6 convolution custom instruction path. Each accepted operation splits two XLEN operands into LANES equal lanes and multiplies lane pairs with per-operand signedness. It reduces the products, then either starts or extends a running accumulator. A valid/ready handshake with backpressure on both sides lets it sit behind the issue stage and in front of the writeback arbiter.

## Interface
- XLEN, 32, operand and result width.
- LANES, 4, lanes per operand. Must be a power of two that divides XLEN; lane width W = XLEN/LANES.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  operation offered.
- in_ready_o  out  1  operation accepted when in_valid_i && in_ready_o.
- operand_a_i  in  XLEN  kernel lanes; lane k is bits [k*W+W-1 : k*W].
- operand_b_i  in  XLEN  image lanes, same packing as operand_a_i.
- a_signed_i  in  1  1: lanes of a are two's complement; 0: unsigned.
- b_signed_i  in  1  same meaning, for b.
- acc_en_i  in  1  1: add the dot product to the accumulator; 0: load the accumulator with the dot product.
- flush_i  in  1  drop in-flight operations and zero the accumulator.
- out_valid_o  out  1  result_o holds a valid result.
- out_ready_i  in  1  consumer takes the result.
- result_o  out  XLEN  accumulator value after this operation.
- sat_o  out  1  this result saturated (only when MAC_SATURATE_EN is defined).

## Operation
- Reset values: in_ready_o=1, out_valid_o=0, result_o=0, sat_o=0. All stage valid bits are 0 and the accumulator is 0.
- Three-stage pipeline, one operation per stage, with a valid bit per stage:
  - S1 multiply: lane k forms a (W+1)x(W+1) signed product. Each operand is extended by 1 bit: sign bit if its signed flag is set, 0 if clear. The product is 2W+2 bits.
  - S2 reduce: combinational adder tree over all lane products, registered once. Sum width SUM_W = 2W+2+clog2(LANES), sign-extended at every level.
  - S3 accumulate: the sum is sign-extended or truncated to XLEN.
    - acc_en=1: acc <= acc + sum.
    - acc_en=0: acc <= sum.
    - result_o mirrors acc; out_valid_o mirrors the S3 valid bit.
- acc_en, a_signed and b_signed travel with the operation through the pipeline and are not sampled globally.
- Stall rule: advance = !out_valid_o || out_ready_i, and in_ready_o = advance.
  - On advance, every stage shifts by one. Bubbles propagate as valid=0.
  - When advance=0, every stage holds, and result_o and sat_o are stable.
- The accumulator changes only when a valid operation enters S3. Bubbles leave it untouched.
- flush_i has priority over everything except rst_i. On the next edge it clears every valid bit, acc and sat_o, and ignores any handshake in that cycle. in_ready_o stays 1 during flush.
- Simultaneous accept and output: the normal case. A pipeline that is full and draining sustains 1 operation per cycle.
- rst_i mid-operation: every in-flight operation is lost and the outputs return to their reset values on the next edge.

## Timing
- Latency: an operation accepted at edge N gives out_valid_o=1 with its result after edge N+3, provided advance stays 1.
- Throughput: 1 operation per cycle.
- out_valid_o stays asserted and result_o stays constant until out_ready_i is sampled high.
- No combinational path from in_valid_i to any output. in_ready_o depends combinationally on out_ready_i.

## Configuration
- MAC_SATURATE_EN defined:
  - S3 computes acc + sum at XLEN+1 bits.
  - On signed overflow it clamps to 0x7FFF_FFFF or 0x8000_0000 (for XLEN=32) and sets sat_o=1 for that result.
  - A load with acc_en=0 whose sum does not fit XLEN also clamps.
- MAC_SATURATE_EN undefined: the accumulator wraps modulo 2^XLEN and sat_o is tied to 0.

## Structure
- Package mac_pkg holds:
  - the XLEN default;
  - a function computing SUM_W from XLEN and LANES;
  - the op struct {a, b, a_signed, b_signed, acc_en} used for the S1 input register.
- Sub-module mac_lane_mul: one lane's extend-and-multiply, instantiated LANES times in a generate loop.

## Test plan
- Mixed signedness, LANES=4, a=0xFF020304 with a_signed=1, b=0x01020304 with b_signed=0, acc_en=0 -> after 3 cycles out_valid_o=1 and result_o=0x0000001C (16+9+4-1).
- Same operands with a_signed=0 -> result_o=0x0000011C (255+4+9+16).
- Accumulation and bubbles: the first case issued with acc_en=0, then twice with acc_en=1, back-to-back -> results 0x1C, 0x38, 0x54 on consecutive cycles. Repeating the run with one idle cycle between operations gives the same values.
- Backpressure: 5 operations offered while out_ready_i=0 for 4 cycles after the first result -> in_ready_o=0 while stalled, result_o stable, no result lost or duplicated, all 5 delivered in order.
- Saturation, LANES=2: a=b=0x80008000 with both signed, acc_en=0 -> with the macro, result_o=0x7FFFFFFF and sat_o=1; without it, result_o=0x80000000 and sat_o=0.
- flush_i and rst_i asserted with 3 operations in flight -> the next cycle out_valid_o=0 and acc=0. The following operation with acc_en=1, a=0x01, b=0x05 returns result_o=0x5.
